// File: rtl/dn_port_arbiter.sv
// dn_port_arbiter: shares the download/NVRAM port between the HPS ioctl stream and the hiscore engine
module dn_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter logic [7:0] NV_INDEX = 8'd4,
  parameter int PAUSE_SETTLE = 4,
  parameter int WAIT_TIMEOUT = 1023
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_index,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic          hs_wr,
  input  logic [DW-1:0] hs_wdata,
  output logic          hs_gnt,
  output logic          hs_abort,
  output logic [DW-1:0] hs_rdata,
  output logic          pause_req,
  input  logic          paused,
  output logic [AW-1:0] dn_addr,
  output logic [DW-1:0] dn_data,
  output logic          dn_wr,
  output logic          dn_nvram_wr,
  output logic          dn_nvram,
  input  logic [DW-1:0] dn_din
);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, HPS, PAUSE_WAIT, SETTLE, HS_GRANT, RELEASE} state_t;
  state_t r_state;
  logic [TW-1:0] r_timer;
  logic [3:0] r_settle;
  logic w_hps, w_rom, w_nv, w_idle_hps;
  assign w_idle_hps = (r_state == IDLE) || (r_state == HPS);
  // a download starting in IDLE already owns the port on that cycle
  assign w_hps = ioctl_download && w_idle_hps;
  assign w_rom = ioctl_index == ROM_INDEX;
  assign w_nv = ioctl_index == NV_INDEX;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_settle <= '0;
      ioctl_wait <= 1'b0;
      hs_gnt <= 1'b0;
      hs_abort <= 1'b0;
      hs_rdata <= '0;
      pause_req <= 1'b0;
      dn_addr <= '0;
      dn_data <= '0;
      dn_wr <= 1'b0;
      dn_nvram_wr <= 1'b0;
      dn_nvram <= 1'b0;
    end else begin
      dn_wr <= 1'b0;
      dn_nvram_wr <= 1'b0;
      hs_abort <= 1'b0;
      hs_rdata <= dn_din;
      ioctl_wait <= ioctl_download && !w_idle_hps;
      if (w_hps) begin
        dn_addr <= ioctl_addr;
        dn_data <= ioctl_dout;
        dn_wr <= ioctl_wr && w_rom;
        dn_nvram_wr <= ioctl_wr && w_nv;
        dn_nvram <= w_nv;
      end
      case (r_state)
        IDLE:
          if (ioctl_download) r_state <= HPS;
          else if (hs_req) begin
            r_state <= PAUSE_WAIT;
            pause_req <= 1'b1;
            r_timer <= TW'(1);
          end
        HPS:
          if (!ioctl_download) begin
            r_state <= IDLE;
            dn_nvram <= 1'b0;
          end
        PAUSE_WAIT:
          if (ioctl_download || (!paused && r_timer == TW'(WAIT_TIMEOUT))) begin
            r_state <= IDLE;
            pause_req <= 1'b0;
            hs_abort <= 1'b1;
          end else if (!hs_req) begin
            r_state <= RELEASE;
            pause_req <= 1'b0;
          end else if (paused) begin
            r_state <= SETTLE;
            r_settle <= 4'(PAUSE_SETTLE);
          end else if (r_timer != '1) r_timer <= r_timer + 1'b1;
        SETTLE:
          if (ioctl_download) begin
            r_state <= IDLE;
            pause_req <= 1'b0;
            hs_abort <= 1'b1;
          end else if (!hs_req) begin
            r_state <= RELEASE;
            pause_req <= 1'b0;
          end else if (r_settle <= 4'd1) begin
            r_state <= HS_GRANT;
            hs_gnt <= 1'b1;
            dn_nvram <= 1'b1;
          end else r_settle <= r_settle - 1'b1;
        HS_GRANT:
          if (!hs_req) begin
            r_state <= RELEASE;
            hs_gnt <= 1'b0;
            pause_req <= 1'b0;
            dn_nvram <= 1'b0;
          end else begin
            dn_addr <= hs_addr;
            dn_data <= hs_wdata;
            dn_nvram_wr <= hs_wr;
          end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
